sc_stream_decoder: RTL and testbench
====================================

// Module: sc_stream_decoder
// PURPOSE
//   Downstream stage of the stochastic FSM activation blocks: converts a
//   unipolar/bipolar stochastic bit-stream back to binary.
//   - Counts ones over a fixed window of N = 2**W valid samples.
//   - Presents both the raw ones-count and the bipolar value.
//   - Uses a start/busy/done handshake; a continuous mode runs back-to-back windows.
// PARAMETERS
//   W     8   log2 of the window length; N = 2**W samples per window
//   CONT  0   1 = restart automatically after each window; 0 = one-shot on start
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request a new window; sampled only in IDLE
//   x      in   1      stochastic input bit (e.g. FSM activation output y)
//   x_vld  in   1      x is a valid sample this cycle
//   busy   out  1      high while state==RUN
//   done   out  1      one-cycle pulse: count/bip updated on the preceding edge
//   count  out  W+1    ones in the last completed window, 0..N (unsigned)
//   bip    out  W+2    2*count - N, two's complement, range -N..+N
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, acc=0, ncnt=0, busy=0, done=0,
//     count=0, bip=-N (consistent with count=0); held while rst=1.
//   FSM: IDLE, RUN.
//     IDLE: start=1 at edge k -> RUN; acc<=0, ncnt<=0. No sample taken at edge k.
//     RUN: each edge with x_vld=1 -> acc+=x, ncnt+=1. x_vld=0 -> acc, ncnt hold.
//     Last sample (ncnt==N-1 and x_vld=1):
//       - count<=acc+x and bip<=2*(acc+x)-N on the same edge; done<=1 next cycle.
//       - CONT=0: -> IDLE. CONT=1: stay RUN, acc<=0, ncnt<=0, no lost sample.
//   Latency: start at edge k with x_vld always 1 -> samples on edges k+1..k+N;
//     done high during cycle after edge k+N.
//   start while busy: ignored, no effect on window.
//   start in the same cycle a one-shot window ends (state RUN): ignored; needs IDLE.
//   done: exactly one cycle per completed window; never asserted for aborted windows.
//   count/bip: hold last result until next completed window; never show partial sums.
//   Widths: acc and ncnt are W+1 bits. acc is guaranteed <= N, so no wrap;
//     ncnt never reaches N, because it is cleared at the last sample.
//   rst asserted mid-window: window discarded, all state returns to reset values.
//   Inputs x and x_vld are synchronous to clk; no internal synchronisers.
// TESTING
//   W=8, CONT=0, start pulse, x=1, x_vld=1 for 256 cycles -> done once;
//     count=256, bip=+256, busy falls with done.
//   Same with x=0 -> count=0, bip=-256.
//   x alternating 1,0 -> count=128, bip=0.
//   x=1 with x_vld=0 on every 3rd cycle -> window spans 384 cycles; count=256.
//   start re-pulsed at sample 100 -> ignored; done at sample 256 only.
//   rst pulsed at sample 50 -> busy=0, count=0, bip=-256, no done.
//   CONT=1, x=1 for 3 windows -> done pulses 256 cycles apart, count=256 each time.
//   Randomized Bernoulli(p=0.75) stream vs reference model -> exact count match.

Source files
------------

// File: rtl/sc_stream_decoder.sv
// Stochastic bit-stream decoder: counts ones over a 2**W-sample window and
// reports the unsigned ones-count plus the bipolar value 2*count - N.
module sc_stream_decoder #(
  parameter int W    = 8,
  parameter bit CONT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           x,
  input  logic           x_vld,
  output logic           busy,
  output logic           done,
  output logic [W:0]     count,
  output logic [W+1:0]   bip
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [W:0]   ZERO_W1   = {(W+1){1'b0}};
  localparam logic [W:0]   ONE_W1    = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   NCNT_LAST = {1'b0, {W{1'b1}}};
  localparam logic [W+1:0] N_BIP     = {2'b01, {W{1'b0}}};
  // -N in W+2 bits, matching count == 0 after reset
  localparam logic [W+1:0] BIP_RST   = {2'b11, {W{1'b0}}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W:0]   r_acc;
  logic [W:0]   w_acc_nxt;
  logic [W:0]   r_ncnt;
  logic [W:0]   w_ncnt_nxt;
  logic [W:0]   r_count;
  logic [W:0]   w_count_nxt;
  logic [W+1:0] r_bip;
  logic [W+1:0] w_bip_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         r_busy;
  logic [W:0]   w_sum;
  logic [W+1:0] w_bip_calc;

  // Running sum including the current sample; acc <= N-1 here, so no wrap.
  assign w_sum      = r_acc + {{W{1'b0}}, x};
  assign w_bip_calc = {w_sum, 1'b0} - N_BIP;

  // Next-state, accumulator and result update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ncnt_nxt  = r_ncnt;
    w_count_nxt = r_count;
    w_bip_nxt   = r_bip;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_acc_nxt   = ZERO_W1;
          w_ncnt_nxt  = ZERO_W1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (x_vld) begin
          if (r_ncnt == NCNT_LAST) begin
            // Last sample: publish result and rearm counters on the same edge
            w_count_nxt = w_sum;
            w_bip_nxt   = w_bip_calc;
            w_done_nxt  = 1'b1;
            w_acc_nxt   = ZERO_W1;
            w_ncnt_nxt  = ZERO_W1;
            if (CONT) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_acc_nxt  = w_sum;
            w_ncnt_nxt = r_ncnt + ONE_W1;
          end
        end else begin
          w_acc_nxt  = r_acc;
          w_ncnt_nxt = r_ncnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = ZERO_W1;
        w_ncnt_nxt  = ZERO_W1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= ZERO_W1;
      r_ncnt  <= ZERO_W1;
      r_count <= ZERO_W1;
      r_bip   <= BIP_RST;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ncnt  <= w_ncnt_nxt;
      r_count <= w_count_nxt;
      r_bip   <= w_bip_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
  assign bip   = r_bip;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder: one-shot instance (CONT=0) and
// continuous instance (CONT=1) sharing clock, reset and input stream.
module tb_sc_stream_decoder;
  localparam int W = 8;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0;
  logic         start1;
  logic         x;
  logic         x_vld;
  logic         busy0, done0, busy1, done1;
  logic [W:0]   count0, count1;
  logic [W+1:0] bip0, bip1;

  int n_tests = 0;
  int n_fail  = 0;

  sc_stream_decoder #(.W(W), .CONT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .x(x), .x_vld(x_vld),
    .busy(busy0), .done(done0), .count(count0), .bip(bip0)
  );

  sc_stream_decoder #(.W(W), .CONT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x), .x_vld(x_vld),
    .busy(busy1), .done(done1), .count(count1), .bip(bip1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Stream patterns: 0 ones, 1 zeros, 2 alternating 1/0, 3 ones with every
  // 3rd cycle invalid, 4 Bernoulli(0.75)
  task automatic gen(input int mode, input int c, output logic xo, output logic vo);
    vo = 1'b1;
    case (mode)
      0: xo = 1'b1;
      1: xo = 1'b0;
      2: xo = (c % 2 == 0);
      3: begin xo = 1'b1; vo = (c % 3 != 0); end
      default: xo = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic run_oneshot(input string tag, input int mode, input int exp_count,
                             input int exp_done_at, input int prev_count,
                             input int restart_a, input int restart_b);
    int         done_n = 0;
    int         done_at = -1;
    int         valid_n = 0;
    int         model = 0;
    int         expc;
    logic       xv, vv;
    logic       busy_at = 1'b1;
    logic [W:0] cnt_at = '0;
    logic [W+1:0] bip_at = '0;
    start0 = 1'b1;
    x_vld  = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    check({tag, "_busy_rise"}, busy0, 1);
    for (int c = 0; c < exp_done_at + 20; c++) begin
      gen(mode, c, xv, vv);
      x     = xv;
      x_vld = vv;
      if (vv && valid_n < N) model += int'(xv);
      if (vv) valid_n++;
      start0 = (c == restart_a) || (c == restart_b);
      @(posedge clk); #1;
      start0 = 1'b0;
      if (c == 10) check({tag, "_hold_mid"}, count0, prev_count);
      if (done0 === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          cnt_at  = count0;
          bip_at  = bip0;
          busy_at = busy0;
        end
      end
    end
    expc = (mode == 4) ? model : exp_count;
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_at"}, done_at, exp_done_at);
    check({tag, "_count"}, cnt_at, expc);
    check({tag, "_bip"}, $signed(bip_at), 2 * expc - N);
    check({tag, "_busy_fall"}, busy_at, 0);
    check({tag, "_idle_after"}, busy0, 0);
    check({tag, "_count_hold"}, count0, expc);
  endtask

  initial begin
    int q[$];
    int dn;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    x      = 1'b0;
    x_vld  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_count0", count0, 0);
    check("rst_bip0", $signed(bip0), -256);
    check("rst_busy1", busy1, 0);
    check("rst_bip1", $signed(bip1), -256);
    rst = 1'b0;
    @(posedge clk); #1;

    run_oneshot("ones",  0, 256, 255, 0,   -1, -1);
    run_oneshot("zeros", 1, 0,   255, 256, -1, -1);
    run_oneshot("alt",   2, 128, 255, 0,   -1, -1);
    run_oneshot("gaps",  3, 256, 383, 128, -1, -1);
    // restart mid-window and on the final sample must both be ignored
    run_oneshot("restart", 0, 256, 255, 256, 100, 255);

    // Abort a window after 50 samples with an asynchronous reset
    start0 = 1'b1;
    x = 1'b1;
    x_vld = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    x_vld = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("abort_busy_pre", busy0, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_count", count0, 0);
    check("abort_bip", $signed(bip0), -256);
    check("abort_done", done0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_idle", busy0, 0);

    run_oneshot("random", 4, 0, 255, 0, -1, -1);

    // Continuous instance: three back-to-back windows of all ones
    x = 1'b1;
    x_vld = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 0; c < 3 * N + 10; c++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        q.push_back(c);
        check("cont_count", count1, 256);
        check("cont_bip", $signed(bip1), 256);
      end
    end
    check("cont_done_n", q.size(), 3);
    if (q.size() == 3) begin
      check("cont_done0", q[0], 255);
      check("cont_done1", q[1], 511);
      check("cont_done2", q[2], 767);
    end
    check("cont_busy", busy1, 1);
    check("oneshot_quiet", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
